// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default bit timing.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_WAIT_HI = 3'd4
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle-high level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_module.sv
// UART receiver, 8-N-1, LSB first, with mid-bit sampling and stop-bit check.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each decision point.
import uart_pkg::*;

module uart_rx_module #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  state_t                 state, state_nx;
  logic [15:0]            clk_cnt, clk_cnt_nx;
  logic [2:0]             bit_idx, bit_idx_nx;
  logic [DATA_BITS-1:0]   shifter, shifter_nx;
  logic [DATA_BITS-1:0]   data_nx;
  logic                   valid_nx, frame_err_nx;
  logic                   rx_s;
  logic                   rx_bit;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(rx),
    .sync_out(rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Decisions land one cycle late (T+1) so the reload of 1 keeps bit spacing intact.
  localparam logic [15:0] START_T = HALF + 16'd1;
  localparam logic [15:0] BIT_T   = LAST + 16'd1;
  localparam logic [15:0] RELOAD  = 16'd1;

  logic [1:0] rx_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_hist <= 2'b11;
    end else begin
      rx_hist <= {rx_hist[0], rx_s};
    end
  end

  assign rx_bit = maj3(rx_hist[1], rx_hist[0], rx_s);
`else
  localparam logic [15:0] START_T = HALF;
  localparam logic [15:0] BIT_T   = LAST;
  localparam logic [15:0] RELOAD  = 16'd0;

  assign rx_bit = rx_s;
`endif

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      clk_cnt   <= 16'd0;
      bit_idx   <= 3'd0;
      shifter   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      clk_cnt   <= clk_cnt_nx;
      bit_idx   <= bit_idx_nx;
      shifter   <= shifter_nx;
      data      <= data_nx;
      valid     <= valid_nx;
      frame_err <= frame_err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    clk_cnt_nx   = clk_cnt;
    bit_idx_nx   = bit_idx;
    shifter_nx   = shifter;
    data_nx      = data;
    valid_nx     = 1'b0;
    frame_err_nx = 1'b0;

    case (state)
      S_IDLE: begin
        clk_cnt_nx = 16'd0;
        if (!rx_s) state_nx = S_START;
      end

      S_START: begin
        if (clk_cnt == START_T) begin
          if (!rx_bit) begin
            state_nx   = S_DATA;
            clk_cnt_nx = RELOAD;
            bit_idx_nx = 3'd0;
          end else begin
            state_nx   = S_IDLE;
            clk_cnt_nx = 16'd0;
          end
        end else begin
          clk_cnt_nx = clk_cnt + 16'd1;
        end
      end

      S_DATA: begin
        if (clk_cnt == BIT_T) begin
          shifter_nx = {rx_bit, shifter[DATA_BITS-1:1]};
          clk_cnt_nx = RELOAD;
          bit_idx_nx = bit_idx + 3'd1;
          if (bit_idx == 3'(DATA_BITS - 1)) state_nx = S_STOP;
        end else begin
          clk_cnt_nx = clk_cnt + 16'd1;
        end
      end

      // Leaving at the stop-bit midpoint lets an immediately following start bit be caught.
      S_STOP: begin
        if (clk_cnt == BIT_T) begin
          clk_cnt_nx = 16'd0;
          if (rx_bit) begin
            data_nx  = shifter;
            valid_nx = 1'b1;
            state_nx = S_IDLE;
          end else begin
            frame_err_nx = 1'b1;
            state_nx     = S_WAIT_HI;
          end
        end else begin
          clk_cnt_nx = clk_cnt + 16'd1;
        end
      end

      S_WAIT_HI: begin
        clk_cnt_nx = 16'd0;
        if (rx_s) state_nx = S_IDLE;
      end

      default: begin
        state_nx   = S_IDLE;
        clk_cnt_nx = 16'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_module.sv
// Directed bench for uart_rx_module: bit-banged frames on rx, expected bytes queued per frame
// and popped by a monitor on every valid pulse.
module tb_uart_rx_module;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int         checks_total  = 0;
  int         checks_passed = 0;
  int         checks_failed = 0;
  int         valid_cnt     = 0;
  int         ferr_cnt      = 0;
  int         busy_cycles;
  logic       prev_valid    = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_module #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives start, 8 data bits LSB first, stop; glitch_bit >= 0 inverts that data bit for one mid-bit cycle.
  task automatic applyStimulus(input logic [7:0] value, input logic stop_val, input int glitch_bit);
    logic [9:0] frame;
    frame = {stop_val, value, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (glitch_bit >= 0 && b == glitch_bit + 1 && c == CPB / 2) rx = ~frame[b];
        else rx = frame[b];
        tick(1);
      end
    end
  endtask

  task automatic waitValid(input int target, input string tag);
    int budget;
    budget = 48 * CPB;
    while (valid_cnt < target && budget > 0) begin
      tick(1);
      budget--;
    end
    checkOutput(tag, valid_cnt, target);
  endtask

  always @(negedge clk) begin
    if (valid || frame_err) checkOutput("valid_ferr_exclusive", {31'b0, valid & frame_err}, 32'd0);
    if (valid) begin
      valid_cnt++;
      checkOutput("valid_one_cycle", {31'b0, prev_valid}, 32'd0);
      checkOutput("scoreboard_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) checkOutput("rx_data", {24'b0, data}, {24'b0, exp_q.pop_front()});
    end
    if (frame_err) ferr_cnt++;
    prev_valid = valid;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    checkOutput("reset_data", {24'b0, data}, 32'd0);
    checkOutput("reset_valid", {31'b0, valid}, 32'd0);
    checkOutput("reset_frame_err", {31'b0, frame_err}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    tick(CPB);

    $display("[TB] single frame 0xA5");
    exp_q.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b1, -1);
    rx = 1'b1;
    waitValid(1, "t1_valid_count");
    checkOutput("t1_data", {24'b0, data}, 32'hA5);
    checkOutput("t1_no_ferr", ferr_cnt, 32'd0);

    $display("[TB] back-to-back 0x00 0xFF 0x3C");
    exp_q.push_back(8'h00);
    applyStimulus(8'h00, 1'b1, -1);
    exp_q.push_back(8'hFF);
    applyStimulus(8'hFF, 1'b1, -1);
    exp_q.push_back(8'h3C);
    applyStimulus(8'h3C, 1'b1, -1);
    rx = 1'b1;
    waitValid(4, "t2_valid_count");
    checkOutput("t2_data_last", {24'b0, data}, 32'h3C);
    checkOutput("t2_no_ferr", ferr_cnt, 32'd0);

    $display("[TB] 4-cycle start glitch");
    tick(CPB);
    busy_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      rx = (i < 4) ? 1'b0 : 1'b1;
      tick(1);
      if (busy) busy_cycles++;
    end
    checkOutput("t3_busy_seen", {31'b0, busy_cycles > 0}, 32'd1);
    checkOutput("t3_busy_bound", {31'b0, busy_cycles <= HALF + 3}, 32'd1);
    checkOutput("t3_idle", {31'b0, busy}, 32'd0);
    checkOutput("t3_no_valid", valid_cnt, 32'd4);

    $display("[TB] stop bit low, line held low, then 0x81");
    tick(CPB);
    applyStimulus(8'h55, 1'b0, -1);
    rx = 1'b0;
    tick(40);
    checkOutput("t4_ferr_once", ferr_cnt, 32'd1);
    checkOutput("t4_busy_wait_hi", {31'b0, busy}, 32'd1);
    checkOutput("t4_data_held", {24'b0, data}, 32'h3C);
    checkOutput("t4_no_valid", valid_cnt, 32'd4);
    rx = 1'b1;
    tick(CPB);
    checkOutput("t4_idle_after_release", {31'b0, busy}, 32'd0);
    exp_q.push_back(8'h81);
    applyStimulus(8'h81, 1'b1, -1);
    rx = 1'b1;
    waitValid(5, "t4_valid_count");
    checkOutput("t4_data_after", {24'b0, data}, 32'h81);

    $display("[TB] reset during bit 4");
    tick(CPB);
    rx = 1'b0;
    tick(CPB);
    for (int b = 0; b < 4; b++) begin
      rx = b[0];
      tick(CPB);
    end
    rx = 1'b1;
    tick(CPB / 2);
    checkOutput("t5_busy_before_rst", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    tick(1);
    checkOutput("t5_busy", {31'b0, busy}, 32'd0);
    checkOutput("t5_valid", {31'b0, valid}, 32'd0);
    checkOutput("t5_data", {24'b0, data}, 32'd0);
    rst = 1'b0;
    tick(2 * CPB);
    checkOutput("t5_no_pulse", valid_cnt, 32'd5);
    exp_q.push_back(8'h12);
    applyStimulus(8'h12, 1'b1, -1);
    rx = 1'b1;
    waitValid(6, "t5_valid_count");
    checkOutput("t5_data_after", {24'b0, data}, 32'h12);

    $display("[TB] mid-bit glitch on bit 2 of 0xF0");
    tick(CPB);
`ifdef UART_RX_MAJORITY_EN
    exp_q.push_back(8'hF0);
`else
    exp_q.push_back(8'hF4);
`endif
    applyStimulus(8'hF0, 1'b1, 2);
    rx = 1'b1;
    waitValid(7, "t6_valid_count");

    tick(CPB);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    checkOutput("total_ferr", ferr_cnt, 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
